// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: next-PC select codes, fetch FSM states, widths.
// Also imported by the main control FSM for the NPCOp encodings.
package fetch_unit_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 6;
    localparam int REG_W = 5;
    localparam int IMM_W = 16;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection; shared with future pipelined fetch variants.
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] ir,
    input  logic [XLEN-1:0] rs_data,
    input  logic [1:0]      npc_op,
    output logic [XLEN-1:0] npc
);

    logic [XLEN-1:0] br_off;
    logic            unused_bits;

    // pc has already been advanced by 4 when a branch resolves
    assign br_off      = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign unused_bits = ^{ir[31:26], rs_data[1:0]};

    always_comb begin
        npc = pc + 32'd4;
        unique case (npc_op_e'(npc_op))
            NPC_PLUS4:  npc = pc + 32'd4;
            NPC_BRANCH: npc = pc + br_off;
            NPC_JUMP:   npc = {pc[31:28], ir[25:0], 2'b00};
            NPC_JR:     npc = {rs_data[31:2], 2'b00};
            default:    npc = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage of the multicycle MIPS core: PC, IR, next-PC, imem handshake.
// Optional stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET       = 32'h0000_3000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWr,
    input  logic              IRWr,
    input  logic [1:0]        NPCOp,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              imem_ack,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   ir,
    output logic [OP_W-1:0]   op,
    output logic [OP_W-1:0]   funct,
    output logic [REG_W-1:0]  rs,
    output logic [REG_W-1:0]  rt,
    output logic [REG_W-1:0]  rd,
    output logic [IMM_W-1:0]  imm16,
    output logic              fetch_busy,
    output logic              fetch_fault,
    output logic [XLEN-1:0]   stall_count
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    fetch_state_e    state;
    fetch_state_e    state_n;
    logic [7:0]      timer;
    logic [XLEN-1:0] npc;
    logic            in_idle;
    logic            tmo;

    assign in_idle = (state == F_IDLE);
    // An ack in the last timer cycle wins over the timeout
    assign tmo     = (state == F_REQ) && !imem_ack && (timer == TMO_LAST);

    npc_calc u_npc (
        .pc      (pc),
        .ir      (ir),
        .rs_data (rs_data),
        .npc_op  (NPCOp),
        .npc     (npc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= F_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            F_IDLE:  if (IRWr) state_n = F_REQ;
            F_REQ:   if (imem_ack || tmo) state_n = F_IDLE;
            default: state_n = F_IDLE;
        endcase
    end

    always_comb begin
        fetch_busy = (state == F_REQ);
        imem_req   = (state == F_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= PC_RESET;
            ir          <= INSTR_NOP;
            imem_addr   <= '0;
            timer       <= '0;
            fetch_fault <= 1'b0;
        end else begin
            if (in_idle && PCWr)
                pc <= {npc[31:2], 2'b00};
            if (in_idle && IRWr) begin
                imem_addr <= pc;
                timer     <= '0;
            end else if (!in_idle) begin
                timer <= timer + 8'd1;
            end
            if (!in_idle) begin
                if (imem_ack) begin
                    ir <= imem_rdata;
                end else if (tmo) begin
                    ir          <= INSTR_NOP;
                    fetch_fault <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [XLEN-1:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (fetch_busy && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

    assign op    = ir[31:26];
    assign funct = ir[5:0];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign imm16 = ir[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expected IR words queued at launch,
// checked when the fetch completes.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWr;
    logic        IRWr;
    logic [1:0]  NPCOp;
    logic [31:0] rs_data;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        fetch_busy;
    logic        fetch_fault;
    logic [31:0] stall_count;

`ifdef FETCH_STALL_CNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    fetch_unit #(
        .PC_RESET       (32'h0000_3000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWr        (PCWr),
        .IRWr        (IRWr),
        .NPCOp       (NPCOp),
        .rs_data     (rs_data),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .ir          (ir),
        .op          (op),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
        .fetch_busy  (fetch_busy),
        .fetch_fault (fetch_fault),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_stall = 32'd0;

    function automatic logic [31:0] stall_exp();
        return STALL_ON ? exp_stall : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch a fetch and ack it in REQ cycle 'delay'; returns busy cycles seen
    task automatic do_fetch(input logic pcwr, input logic [1:0] nop,
                            input logic [31:0] word, input int delay,
                            input bit pulse, output int busy_n);
        IRWr  = 1'b1;
        PCWr  = pcwr;
        NPCOp = nop;
        sb.push_back(word);
        step();
        IRWr   = 1'b0;
        PCWr   = 1'b0;
        busy_n = 0;
        for (int k = 1; k <= delay; k++) begin
            if (fetch_busy) busy_n++;
            if (k == delay) begin
                imem_ack   = 1'b1;
                imem_rdata = word;
            end
            if (pulse && k == 2) begin
                IRWr  = 1'b1;
                PCWr  = 1'b1;
                NPCOp = 2'b00;
            end
            step();
            IRWr       = 1'b0;
            PCWr       = 1'b0;
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        exp_stall += 32'(delay);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        NPCOp      = 2'b00;
        rs_data    = 32'h0;
        imem_rdata = 32'h0;
        imem_ack   = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        n_cmp++; if (pc !== 32'h3000) begin n_bad++; $display("FAIL rst_pc got %h want %h", pc, 32'h3000); end
        n_cmp++; if (ir !== 32'h0) begin n_bad++; $display("FAIL rst_ir got %h want 0", ir); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        n_cmp++; if (fetch_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", fetch_busy); end
        n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %b want 0", fetch_fault); end
        n_cmp++; if (stall_count !== 32'h0) begin n_bad++; $display("FAIL rst_stall got %h want 0", stall_count); end
    endtask

    task automatic test_plus4();
        int b;
        logic [31:0] e;
        do_fetch(1'b1, 2'b00, 32'h3408_0005, 1, 1'b0, b);
        e = sb.pop_front();
        n_cmp++; if (ir !== e) begin n_bad++; $display("FAIL p4_ir got %h want %h", ir, e); end
        n_cmp++; if (b !== 1) begin n_bad++; $display("FAIL p4_busy_cycles got %0d want 1", b); end
        n_cmp++; if (imem_addr !== 32'h3000) begin n_bad++; $display("FAIL p4_addr got %h want %h", imem_addr, 32'h3000); end
        n_cmp++; if (pc !== 32'h3004) begin n_bad++; $display("FAIL p4_pc got %h want %h", pc, 32'h3004); end
        n_cmp++; if (op !== 6'h0D) begin n_bad++; $display("FAIL p4_op got %h want 0d", op); end
        n_cmp++; if (rt !== 5'd8 || rs !== 5'd0) begin n_bad++; $display("FAIL p4_rsrt got %0d/%0d want 0/8", rs, rt); end
        n_cmp++; if (imm16 !== 16'h0005) begin n_bad++; $display("FAIL p4_imm got %h want 0005", imm16); end
        n_cmp++; if (fetch_busy !== 1'b0) begin n_bad++; $display("FAIL p4_busy_end got %b want 0", fetch_busy); end
    endtask

    task automatic test_slow_ack();
        int b;
        logic [31:0] e;
        do_fetch(1'b0, 2'b00, 32'h2008_0001, 5, 1'b1, b);
        e = sb.pop_front();
        n_cmp++; if (ir !== e) begin n_bad++; $display("FAIL slow_ir got %h want %h", ir, e); end
        n_cmp++; if (b !== 5) begin n_bad++; $display("FAIL slow_busy_cycles got %0d want 5", b); end
        n_cmp++; if (pc !== 32'h3004) begin n_bad++; $display("FAIL slow_pc got %h want %h", pc, 32'h3004); end
        n_cmp++; if (imem_addr !== 32'h3004) begin n_bad++; $display("FAIL slow_addr got %h want %h", imem_addr, 32'h3004); end
        n_cmp++; if (funct !== 6'h01) begin n_bad++; $display("FAIL slow_funct got %h want 01", funct); end
        step();
        n_cmp++; if (fetch_busy !== 1'b0) begin n_bad++; $display("FAIL slow_single got %b want 0", fetch_busy); end
        n_cmp++; if (stall_count !== stall_exp()) begin n_bad++; $display("FAIL slow_stall got %0d want %0d", stall_count, stall_exp()); end
    endtask

    task automatic test_branch_jump();
        int b;
        logic [31:0] e;
        do_fetch(1'b1, 2'b00, 32'h1000_FFFE, 1, 1'b0, b);
        e = sb.pop_front();
        n_cmp++; if (ir !== e) begin n_bad++; $display("FAIL br_ir got %h want %h", ir, e); end
        n_cmp++; if (pc !== 32'h3008) begin n_bad++; $display("FAIL br_pc0 got %h want %h", pc, 32'h3008); end
        PCWr  = 1'b1;
        NPCOp = 2'b01;
        step();
        PCWr = 1'b0;
        n_cmp++; if (pc !== 32'h3000) begin n_bad++; $display("FAIL br_pc got %h want %h", pc, 32'h3000); end
        n_cmp++; if (ir !== 32'h1000_FFFE) begin n_bad++; $display("FAIL br_ir_kept got %h want %h", ir, 32'h1000_FFFE); end
        do_fetch(1'b0, 2'b00, 32'h0800_0C10, 1, 1'b0, b);
        e = sb.pop_front();
        n_cmp++; if (ir !== e) begin n_bad++; $display("FAIL j_ir got %h want %h", ir, e); end
        PCWr  = 1'b1;
        NPCOp = 2'b10;
        step();
        PCWr = 1'b0;
        n_cmp++; if (pc !== 32'h3040) begin n_bad++; $display("FAIL j_pc got %h want %h", pc, 32'h3040); end
    endtask

    task automatic test_jr_wrap();
        PCWr    = 1'b1;
        NPCOp   = 2'b11;
        rs_data = 32'h0000_4007;
        step();
        n_cmp++; if (pc !== 32'h4004) begin n_bad++; $display("FAIL jr_pc got %h want %h", pc, 32'h4004); end
        rs_data = 32'hFFFF_FFFF;
        step();
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL jr_top got %h want fffffffc", pc); end
        NPCOp = 2'b00;
        step();
        PCWr = 1'b0;
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got %h want 0", pc); end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        n_cmp++; if (ir !== 32'h0800_0C10) begin n_bad++; $display("FAIL idle_ack_ir got %h want %h", ir, 32'h0800_0C10); end
        n_cmp++; if (fetch_busy !== 1'b0) begin n_bad++; $display("FAIL idle_ack_busy got %b want 0", fetch_busy); end
    endtask

    task automatic test_ack_at_limit();
        int b;
        logic [31:0] e;
        do_fetch(1'b0, 2'b00, 32'hAC01_0004, 16, 1'b0, b);
        e = sb.pop_front();
        n_cmp++; if (ir !== e) begin n_bad++; $display("FAIL lim_ir got %h want %h", ir, e); end
        n_cmp++; if (b !== 16) begin n_bad++; $display("FAIL lim_busy_cycles got %0d want 16", b); end
        n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL lim_fault got %b want 0", fetch_fault); end
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] e;
        IRWr = 1'b1;
        sb.push_back(32'h0);
        step();
        IRWr = 1'b0;
        n = 0;
        while (fetch_busy && n < 40) begin
            n++;
            step();
        end
        exp_stall += 32'd16;
        e = sb.pop_front();
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL tmo_busy_cycles got %0d want 16", n); end
        n_cmp++; if (fetch_fault !== 1'b1) begin n_bad++; $display("FAIL tmo_fault got %b want 1", fetch_fault); end
        n_cmp++; if (ir !== e) begin n_bad++; $display("FAIL tmo_ir got %h want %h", ir, e); end
        step();
        n_cmp++; if (fetch_fault !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky got %b want 1", fetch_fault); end
        n_cmp++; if (stall_count !== stall_exp()) begin n_bad++; $display("FAIL tmo_stall got %0d want %0d", stall_count, stall_exp()); end
    endtask

    task automatic test_reset_mid_fetch();
        IRWr = 1'b1;
        sb.push_back(32'h5555_5555);
        step();
        IRWr = 1'b0;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL mid_req_before got %b want 1", imem_req); end
        rst = 1'b1;
        #1;
        sb.delete();
        exp_stall = 32'd0;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_req_drop got %b want 0", imem_req); end
        n_cmp++; if (pc !== 32'h3000) begin n_bad++; $display("FAIL mid_pc got %h want %h", pc, 32'h3000); end
        n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL mid_fault got %b want 0", fetch_fault); end
        step();
        rst = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        imem_ack = 1'b0;
        n_cmp++; if (ir !== 32'h0) begin n_bad++; $display("FAIL stray_ir got %h want 0", ir); end
        n_cmp++; if (fetch_busy !== 1'b0) begin n_bad++; $display("FAIL stray_busy got %b want 0", fetch_busy); end
        n_cmp++; if (stall_count !== stall_exp()) begin n_bad++; $display("FAIL stray_stall got %0d want %0d", stall_count, stall_exp()); end
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL sb_left got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_plus4();
        test_slow_ack();
        test_branch_jump();
        test_jr_wrap();
        test_ack_at_limit();
        test_timeout();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
